sprite_pixel_pipe: RTL

Per-pixel sprite resolve stage that sits directly downstream of the bank of `addr_cal` instances, one instance per sprite. Each cycle it selects the highest-priority sprite whose address is valid and issues a single read to the pattern ROM. It realigns the ROM data with delayed `hcount`/`vcount`, applies transparency and emits a colour index to the palette/VGA output stage. It also accumulates per-frame overlap flags against sprite 0 (the player) for software collision detection.

---
 rtl/sprite_pixel_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sprite_pixel_pipe.sv
// Sprite resolve stage: picks the highest-priority valid sprite, reads its pattern ROM
// pixel, realigns it with the raster counters and tracks per-frame overlap with sprite 0.
module sprite_pixel_pipe #(
    parameter int                 NUM_SPRITES = 8,
    parameter int                 ADDR_W      = 16,
    parameter int                 COLOR_W     = 8,
    parameter int                 ROM_LATENCY = 1,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
    parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    input  logic [NUM_SPRITES*ADDR_W-1:0] sprite_addr,
    input  logic [NUM_SPRITES-1:0]        sprite_valid,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_rd,
    input  logic [COLOR_W-1:0]            rom_data,
    output logic [COLOR_W-1:0]            pix_color,
    output logic                          pix_opaque,
    output logic [3:0]                    pix_id,
    output logic [9:0]                    pix_hcount,
    output logic [9:0]                    pix_vcount,
    output logic [NUM_SPRITES-1:0]        coll_status
);

    // Stage 0 is the S1 select register itself; the last stage lines up with rom_data_reg.
    localparam int DEPTH = ROM_LATENCY + 2;
    localparam int LAST  = DEPTH - 1;

    logic              sel_hit;
    logic [3:0]        sel_idx;
    logic [ADDR_W-1:0] sel_addr;

    logic [ADDR_W-1:0] rom_addr_reg;
    logic [9:0]        hc_dly_reg [DEPTH];
    logic [9:0]        vc_dly_reg [DEPTH];
    logic              v_dly_reg  [DEPTH];
    logic [3:0]        id_dly_reg [DEPTH];
    logic [COLOR_W-1:0] rom_data_reg;

    logic [COLOR_W-1:0] pix_color_reg;
    logic               pix_opaque_reg;
    logic [3:0]         pix_id_reg;
    logic [9:0]         pix_hcount_reg;
    logic [9:0]         pix_vcount_reg;

    logic [NUM_SPRITES-1:0] hits;
    logic [NUM_SPRITES-1:0] accum_reg;
    logic [NUM_SPRITES-1:0] coll_status_reg;
    logic                   zero_prev_reg;
    logic                   at_zero;
    logic                   frame_start;

    // Scan downward so the lowest valid index is the last (winning) assignment.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        sel_addr = rom_addr_reg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (sprite_valid[i]) begin
                sel_hit  = 1'b1;
                sel_idx  = 4'(i);
                sel_addr = sprite_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_reg <= '0;
            rom_data_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                hc_dly_reg[k] <= '0;
                vc_dly_reg[k] <= '0;
                v_dly_reg[k]  <= 1'b0;
                id_dly_reg[k] <= '0;
            end
        end else begin
            rom_addr_reg  <= sel_addr;
            rom_data_reg  <= rom_data;
            hc_dly_reg[0] <= hcount;
            vc_dly_reg[0] <= vcount;
            v_dly_reg[0]  <= sel_hit;
            id_dly_reg[0] <= sel_idx;
            for (int k = 1; k < DEPTH; k++) begin
                hc_dly_reg[k] <= hc_dly_reg[k-1];
                vc_dly_reg[k] <= vc_dly_reg[k-1];
                v_dly_reg[k]  <= v_dly_reg[k-1];
                id_dly_reg[k] <= id_dly_reg[k-1];
            end
        end
    end

    // No fall-through: a transparent winner yields background.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_color_reg  <= BG_COLOR;
            pix_opaque_reg <= 1'b0;
            pix_id_reg     <= '0;
            pix_hcount_reg <= '0;
            pix_vcount_reg <= '0;
        end else begin
            pix_hcount_reg <= hc_dly_reg[LAST];
            pix_vcount_reg <= vc_dly_reg[LAST];
            if (v_dly_reg[LAST] && (rom_data_reg != TRANSPARENT)) begin
                pix_color_reg  <= rom_data_reg;
                pix_opaque_reg <= 1'b1;
                pix_id_reg     <= id_dly_reg[LAST];
            end else begin
                pix_color_reg  <= BG_COLOR;
                pix_opaque_reg <= 1'b0;
                pix_id_reg     <= '0;
            end
        end
    end

    assign hits[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_SPRITES; gi++) begin : g_hit
            assign hits[gi] = sprite_valid[0] & sprite_valid[gi];
        end
    endgenerate

    assign at_zero     = (hcount == 10'd0) && (vcount == 10'd0);
    assign frame_start = at_zero && !zero_prev_reg;

    // History resets to "at origin" so the first latch needs the raster to leave (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_prev_reg   <= 1'b1;
            accum_reg       <= '0;
            coll_status_reg <= '0;
        end else begin
            zero_prev_reg <= at_zero;
            if (frame_start) begin
                coll_status_reg <= accum_reg;
                accum_reg       <= hits;
            end else begin
                accum_reg <= accum_reg | hits;
            end
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign rom_rd      = v_dly_reg[0];
    assign pix_color   = pix_color_reg;
    assign pix_opaque  = pix_opaque_reg;
    assign pix_id      = pix_id_reg;
    assign pix_hcount  = pix_hcount_reg;
    assign pix_vcount  = pix_vcount_reg;
    assign coll_status = coll_status_reg;

endmodule
